// File: rtl/seq_signmag_multiplier.sv
// Sequential sign-magnitude multiplier: shift-and-add, one partial product per clock,
// with a start/busy/done handshake and a hex-nibble view of the product for display.
module seq_signmag_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signX,
    input  logic [WIDTH-1:0]     operandX,
    input  logic                 signY,
    input  logic [WIDTH-1:0]     operandY,
    output logic                 busy,
    output logic                 done,
    output logic                 sign_out,
    output logic [2*WIDTH-1:0]   product,
    output logic [3:0]           sign_digit,
    output logic [2*WIDTH-1:0]   digits
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam int               NIBBLES = (2 * WIDTH) / 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_count;
    logic                 r_sign;
    logic                 r_done;
    logic                 r_sign_out;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_sum;

    // A new request is only taken when no multiply is in flight.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_count == LAST);
    assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment before the case keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_DONE;
            S_DONE:  if (start)  w_next_state = S_RUN;
            default:             w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_sign     <= 1'b0;
            r_done     <= 1'b0;
            r_sign_out <= 1'b0;
            r_product  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mcand  <= {{WIDTH{1'b0}}, operandX};
                r_mplier <= operandY;
                r_sign   <= signX ^ signY;
                r_acc    <= '0;
                r_count  <= '0;
            end else if (r_state == S_RUN) begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CNT_W'(1);
                if (w_last) begin
                    // A zero product is always reported as positive.
                    r_product  <= w_sum;
                    r_sign_out <= r_sign && (w_sum != '0);
                    r_done     <= 1'b1;
                end
            end
        end
    end

    assign busy       = (r_state == S_RUN);
    assign done       = r_done;
    assign sign_out   = r_sign_out;
    assign product    = r_product;
    assign sign_digit = {3'b000, r_sign_out};

    for (genvar g = 0; g < NIBBLES; g++) begin : g_digit
        assign digits[4*g +: 4] = r_product[4*g +: 4];
    end

endmodule
